// File: rtl/osyrys64_pkg.sv
// Shared encodings for the osyrys-64 core: major opcodes, NPU function codes
// and the ALU operation select.
package osyrys64_pkg;

    localparam logic [6:0] OPCODE_R   = 7'b0110011;
    localparam logic [6:0] OPCODE_I   = 7'b0010011;
    localparam logic [6:0] OPCODE_L   = 7'b0000011;
    localparam logic [6:0] OPCODE_S   = 7'b0100011;
    localparam logic [6:0] OPCODE_B   = 7'b1100011;
    localparam logic [6:0] OPCODE_NPU = 7'b0001011;

    localparam logic [6:0] FUNCT7_MATRIX_MUL  = 7'b0000001;
    localparam logic [6:0] FUNCT7_CONVOLUTION = 7'b0000010;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_NPU  = 4'd10
    } alu_control_t;

endpackage

// File: rtl/control_unit_if.sv
// Decode-stage bundle: instruction fields in, registered datapath controls out.
interface control_unit_if;
    import osyrys64_pkg::*;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    alu_control_t alu_control;
    logic         reg_write_en;
    logic         alu_src;
    logic         mem_read;
    logic         mem_write;
    logic         mem_to_reg;
    logic         branch;
    logic         is_npu_matrix_mul;
    logic         is_npu_conv;
    logic         illegal_instr;

    modport master (
        output opcode, funct3, funct7,
        input  alu_control, reg_write_en, alu_src, mem_read, mem_write,
               mem_to_reg, branch, is_npu_matrix_mul, is_npu_conv, illegal_instr
    );

    modport slave (
        input  opcode, funct3, funct7,
        output alu_control, reg_write_en, alu_src, mem_read, mem_write,
               mem_to_reg, branch, is_npu_matrix_mul, is_npu_conv, illegal_instr
    );

endinterface

// File: rtl/control_unit.sv
// osyrys-64 main instruction decoder: combinational decode of opcode/funct3/funct7
// into datapath controls, registered for a single cycle of latency.
module control_unit
    import osyrys64_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.slave  bus
);

    typedef struct packed {
        alu_control_t aluControl;
        logic         regWriteEn;
        logic         aluSrc;
        logic         memRead;
        logic         memWrite;
        logic         memToReg;
        logic         branch;
        logic         isNpuMatrixMul;
        logic         isNpuConv;
        logic         illegalInstr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0};

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  illegal;

    always_comb begin
        ctrl_d  = CTRL_IDLE;
        illegal = 1'b0;

        case (bus.opcode)
            OPCODE_R: begin
                ctrl_d.regWriteEn = 1'b1;
                case ({bus.funct7, bus.funct3})
                    10'b0000000_000: ctrl_d.aluControl = ALU_ADD;
                    10'b0100000_000: ctrl_d.aluControl = ALU_SUB;
                    10'b0000000_001: ctrl_d.aluControl = ALU_SLL;
                    10'b0000000_010: ctrl_d.aluControl = ALU_SLT;
                    10'b0000000_011: ctrl_d.aluControl = ALU_SLTU;
                    10'b0000000_100: ctrl_d.aluControl = ALU_XOR;
                    10'b0000000_101: ctrl_d.aluControl = ALU_SRL;
                    10'b0100000_101: ctrl_d.aluControl = ALU_SRA;
                    10'b0000000_110: ctrl_d.aluControl = ALU_OR;
                    10'b0000000_111: ctrl_d.aluControl = ALU_AND;
                    default:         illegal = 1'b1;
                endcase
            end

            // funct7[0] is shamt[5] on 64-bit immediate shifts, so only [6:1] is checked.
            OPCODE_I: begin
                ctrl_d.regWriteEn = 1'b1;
                ctrl_d.aluSrc     = 1'b1;
                case (bus.funct3)
                    3'b000: ctrl_d.aluControl = ALU_ADD;
                    3'b010: ctrl_d.aluControl = ALU_SLT;
                    3'b011: ctrl_d.aluControl = ALU_SLTU;
                    3'b100: ctrl_d.aluControl = ALU_XOR;
                    3'b110: ctrl_d.aluControl = ALU_OR;
                    3'b111: ctrl_d.aluControl = ALU_AND;
                    3'b001: begin
                        if (bus.funct7[6:1] == 6'b000000) ctrl_d.aluControl = ALU_SLL;
                        else                              illegal = 1'b1;
                    end
                    default: begin
                        if (bus.funct7[6:1] == 6'b000000)      ctrl_d.aluControl = ALU_SRL;
                        else if (bus.funct7[6:1] == 6'b010000) ctrl_d.aluControl = ALU_SRA;
                        else                                   illegal = 1'b1;
                    end
                endcase
            end

            OPCODE_L: begin
                ctrl_d.regWriteEn = 1'b1;
                ctrl_d.aluSrc     = 1'b1;
                ctrl_d.memRead    = 1'b1;
                ctrl_d.memToReg   = 1'b1;
                if (bus.funct3 == 3'b111) illegal = 1'b1;
            end

            OPCODE_S: begin
                ctrl_d.aluSrc   = 1'b1;
                ctrl_d.memWrite = 1'b1;
                if (bus.funct3[2]) illegal = 1'b1;
            end

            OPCODE_B: begin
                ctrl_d.branch     = 1'b1;
                ctrl_d.aluControl = ALU_SUB;
                if (bus.funct3 == 3'b010 || bus.funct3 == 3'b011) illegal = 1'b1;
            end

            OPCODE_NPU: begin
                ctrl_d.regWriteEn = 1'b1;
                ctrl_d.aluControl = ALU_NPU;
                if (bus.funct7 == FUNCT7_MATRIX_MUL)       ctrl_d.isNpuMatrixMul = 1'b1;
                else if (bus.funct7 == FUNCT7_CONVOLUTION) ctrl_d.isNpuConv      = 1'b1;
                else                                       illegal = 1'b1;
            end

            default: illegal = 1'b1;
        endcase

        // An illegal encoding drops every enable so nothing downstream acts on it.
        if (illegal) begin
            ctrl_d              = CTRL_IDLE;
            ctrl_d.illegalInstr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ctrl_q <= CTRL_IDLE;
        else     ctrl_q <= ctrl_d;
    end

    assign bus.alu_control       = ctrl_q.aluControl;
    assign bus.reg_write_en      = ctrl_q.regWriteEn;
    assign bus.alu_src           = ctrl_q.aluSrc;
    assign bus.mem_read          = ctrl_q.memRead;
    assign bus.mem_write         = ctrl_q.memWrite;
    assign bus.mem_to_reg        = ctrl_q.memToReg;
    assign bus.branch            = ctrl_q.branch;
    assign bus.is_npu_matrix_mul = ctrl_q.isNpuMatrixMul;
    assign bus.is_npu_conv       = ctrl_q.isNpuConv;
    assign bus.illegal_instr     = ctrl_q.illegalInstr;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each vector carries a hand-written expected
// control word {alu[3:0], rw, src, mr, mw, m2r, br, mm, conv, ill}.
module tb_control_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_NPU = 7'b0001011;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_SLT = 4'd8, A_SLTU = 4'd9, A_NPU = 4'd10;

    // Flag order: rw src mr mw m2r br mm conv ill
    localparam logic [8:0] F_NONE  = 9'b000000000;
    localparam logic [8:0] F_RTYPE = 9'b100000000;
    localparam logic [8:0] F_ITYPE = 9'b110000000;
    localparam logic [8:0] F_LOAD  = 9'b111010000;
    localparam logic [8:0] F_STORE = 9'b010100000;
    localparam logic [8:0] F_BR    = 9'b000001000;
    localparam logic [8:0] F_MM    = 9'b100000100;
    localparam logic [8:0] F_CONV  = 9'b100000010;
    localparam logic [8:0] F_ILL   = 9'b000000001;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [3:0] alu, input logic [8:0] flags);
        return {alu, flags};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.alu_control, bus.reg_write_en, bus.alu_src, bus.mem_read,
                bus.mem_write, bus.mem_to_reg, bus.branch, bus.is_npu_matrix_mul,
                bus.is_npu_conv, bus.illegal_instr};
    endfunction

    task automatic checkOutput(input string tag, input logic [12:0] got, input logic [12:0] want);
        assertCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Drive fields away from the edge, then sample 1 ns after the capturing edge.
    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        bus.opcode = opc;
        bus.funct3 = f3;
        bus.funct7 = f7;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      tag;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [12:0] want;
    } vec_t;

    vec_t vecs[$];

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;

        applyStimulus(OP_R, 3'b000, 7'b0000000);
        checkOutput("reset_cycle1", observed(), mk(A_ADD, F_NONE));
        applyStimulus(OP_R, 3'b000, 7'b0000000);
        checkOutput("reset_cycle2", observed(), mk(A_ADD, F_NONE));
        rst = 1'b0;

        vecs.push_back('{"r_add",        OP_R,   3'b000, 7'b0000000, mk(A_ADD,  F_RTYPE)});
        vecs.push_back('{"r_sub",        OP_R,   3'b000, 7'b0100000, mk(A_SUB,  F_RTYPE)});
        vecs.push_back('{"r_bad_sll",    OP_R,   3'b001, 7'b0100000, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"r_sra",        OP_R,   3'b101, 7'b0100000, mk(A_SRA,  F_RTYPE)});
        vecs.push_back('{"r_sltu",       OP_R,   3'b011, 7'b0000000, mk(A_SLTU, F_RTYPE)});
        vecs.push_back('{"r_and",        OP_R,   3'b111, 7'b0000000, mk(A_AND,  F_RTYPE)});
        vecs.push_back('{"i_or",         OP_I,   3'b110, 7'b1010101, mk(A_OR,   F_ITYPE)});
        vecs.push_back('{"i_slli_sh5",   OP_I,   3'b001, 7'b0000001, mk(A_SLL,  F_ITYPE)});
        vecs.push_back('{"i_srai",       OP_I,   3'b101, 7'b0100001, mk(A_SRA,  F_ITYPE)});
        vecs.push_back('{"i_srli",       OP_I,   3'b101, 7'b0000000, mk(A_SRL,  F_ITYPE)});
        vecs.push_back('{"i_bad_shift",  OP_I,   3'b101, 7'b0000010, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"i_slt",        OP_I,   3'b010, 7'b0000000, mk(A_SLT,  F_ITYPE)});
        vecs.push_back('{"load_lw",      OP_L,   3'b010, 7'b0000000, mk(A_ADD,  F_LOAD)});
        vecs.push_back('{"load_bad",     OP_L,   3'b111, 7'b0000000, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"store_sw",     OP_S,   3'b010, 7'b0000000, mk(A_ADD,  F_STORE)});
        vecs.push_back('{"store_bad",    OP_S,   3'b100, 7'b0000000, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"branch_beq",   OP_B,   3'b000, 7'b0000000, mk(A_SUB,  F_BR)});
        vecs.push_back('{"branch_bad",   OP_B,   3'b011, 7'b0000000, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"npu_matmul",   OP_NPU, 3'b000, 7'b0000001, mk(A_NPU,  F_MM)});
        vecs.push_back('{"npu_conv_f3",  OP_NPU, 3'b101, 7'b0000010, mk(A_NPU,  F_CONV)});
        vecs.push_back('{"npu_bad",      OP_NPU, 3'b000, 7'b0000011, mk(A_ADD,  F_ILL)});
        vecs.push_back('{"bad_opcode",   7'b1111111, 3'b000, 7'b0000000, mk(A_ADD, F_ILL)});
        vecs.push_back('{"r_xor",        OP_R,   3'b100, 7'b0000000, mk(A_XOR,  F_RTYPE)});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].opc, vecs[i].f3, vecs[i].f7);
            checkOutput(vecs[i].tag, observed(), vecs[i].want);
        end

        // Outputs must hold a load decode while the inputs change mid-cycle.
        applyStimulus(OP_L, 3'b011, 7'b0000000);
        checkOutput("load_ld", observed(), mk(A_ADD, F_LOAD));
        bus.opcode = OP_B;
        bus.funct3 = 3'b000;
        #2;
        checkOutput("hold_mid_cycle", observed(), mk(A_ADD, F_LOAD));
        @(posedge clk);
        #1;
        checkOutput("branch_after_edge", observed(), mk(A_SUB, F_BR));

        // Reset takes priority over a legal load in flight.
        applyStimulus(OP_L, 3'b010, 7'b0000000);
        checkOutput("load_before_rst", observed(), mk(A_ADD, F_LOAD));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_over_load", observed(), mk(A_ADD, F_NONE));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("load_after_rst", observed(), mk(A_ADD, F_LOAD));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
